// File: rtl/vp_sng.sv
`default_nettype none
// ============================================================================
//  Module   : vp_sng
//  Purpose  : Variable-precision stochastic number generator. Converts a W-bit
//             operand into a unipolar stochastic bitstream. The comparison
//             value comes from a bit-reversed (van der Corput) counter, so a
//             full stream contains exactly (x & ~ell) >> popcount(ell) ones.
//             The stream length is 2^(W - popcount(ell)).
//  Optional : VPSNG_ABORT_EN - when defined, abort_i ends a running stream
//             early (no done pulse). When undefined, abort_i is ignored.
//  Ports    : clk        clock, rising edge
//             rst_n      synchronous active-low reset
//             start_i    request a new stream (accepted in IDLE only)
//             x_i        operand, captured on accepted start
//             ell_i      precision mask (truncated LSBs), captured on start
//             abort_i    early-termination request (see VPSNG_ABORT_EN)
//             busy_o     high while a stream is running
//             z_valid_o  z_o carries a stream bit this cycle
//             z_o        stochastic bit, 0 when z_valid_o is low
//             z_last_o   final bit of the stream
//             done_o     one-cycle pulse after normal completion
//  Revision : 1.0 - initial release
// ============================================================================
module vp_sng #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] ell_i,
    input  logic         abort_i,
    output logic         busy_o,
    output logic         z_valid_o,
    output logic         z_o,
    output logic         z_last_o,
    output logic         done_o
);

    // Width able to hold 0..W (popcount of ell and the precision p).
    localparam int               c_TW = $clog2(W + 1);
    localparam logic [c_TW-1:0]  c_W  = c_TW'(W);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // ------------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------------
    function automatic logic [c_TW-1:0] f_popcount(input logic [W-1:0] v);
        logic [c_TW-1:0] n;
        n = '0;
        for (int i = 0; i < W; i++) begin
            n = n + c_TW'(v[i]);
        end
        return n;
    endfunction

    // Mask with the low p bits set; the counter value of the last stream bit.
    function automatic logic [W-1:0] f_lowmask(input logic [c_TW-1:0] p);
        logic [W-1:0] m;
        m = '0;
        for (int i = 0; i < W; i++) begin
            m[i] = (i < int'(p));
        end
        return m;
    endfunction

    // bitrev_p(c) << (W - p): bit j of c (j < p) lands on bit W-1-j, so the
    // reversal and the left shift by t collapse into one wiring pattern and
    // t itself never needs to be stored.
    function automatic logic [W-1:0] f_rev(input logic [W-1:0] c,
                                           input logic [c_TW-1:0] p);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            r[W-1-i] = c[i] & (i < int'(p));
        end
        return r;
    endfunction

    // ------------------------------------------------------------------------
    // Abort qualification
    // ------------------------------------------------------------------------
    logic w_abort;
`ifdef VPSNG_ABORT_EN
    assign w_abort = abort_i;
`else
    logic w_unused_abort;
    assign w_unused_abort = abort_i;
    assign w_abort        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [0:0]      state_q, state_d;
    logic [W-1:0]    xm_q,    xm_d;
    logic [c_TW-1:0] p_q,     p_d;
    logic [W-1:0]    c_q,     c_d;

    logic busy_q,    busy_d;
    logic z_valid_q, z_valid_d;
    logic z_q,       z_d;
    logic z_last_q,  z_last_d;
    logic done_q,    done_d;

    logic [c_TW-1:0] w_pop;
    assign w_pop = f_popcount(ell_i);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            xm_q      <= '0;
            p_q       <= '0;
            c_q       <= '0;
            busy_q    <= 1'b0;
            z_valid_q <= 1'b0;
            z_q       <= 1'b0;
            z_last_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            xm_q      <= xm_d;
            p_q       <= p_d;
            c_q       <= c_d;
            busy_q    <= busy_d;
            z_valid_q <= z_valid_d;
            z_q       <= z_d;
            z_last_q  <= z_last_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic. z_last_q already flags that the bit currently on the
    // output is the final one, so it doubles as the terminal-count detect.
    always_comb begin
        state_d = state_q;
        xm_d    = xm_q;
        p_d     = p_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    xm_d    = x_i & ~ell_i;
                    p_d     = c_W - w_pop;
                    c_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (z_last_q) begin
                    state_d = S_IDLE;
                end else if (w_abort) begin
                    state_d = S_IDLE;
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: computed from the next-state values so every output is a
    // flop and the bit for counter value c appears in the cycle c is held.
    always_comb begin
        busy_d    = (state_d == S_RUN);
        z_valid_d = busy_d;
        z_d       = busy_d && (xm_d > f_rev(c_d, p_d));
        z_last_d  = busy_d && (c_d == f_lowmask(p_d));
        // Completion wins over a coincident abort.
        done_d    = (state_q == S_RUN) && z_last_q;
    end

    assign busy_o    = busy_q;
    assign z_valid_o = z_valid_q;
    assign z_o       = z_q;
    assign z_last_o  = z_last_q;
    assign done_o    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_vp_sng.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vp_sng
//  Purpose  : Self-checking bench for vp_sng (W = 8). Expected stream bits are
//             produced by an independent model and queued at start time, then
//             popped and compared as the stream comes out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vp_sng;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] x_i = '0;
    logic [W-1:0] ell_i = '0;
    logic         abort_i = 1'b0;
    logic         busy_o, z_valid_o, z_o, z_last_o, done_o;

    vp_sng #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .x_i       (x_i),
        .ell_i     (ell_i),
        .abort_i   (abort_i),
        .busy_o    (busy_o),
        .z_valid_o (z_valid_o),
        .z_o       (z_o),
        .z_last_o  (z_last_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic z;
        logic last;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ones;
    int   got_ones;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model: bit-reverse the low p bits of c, shift up by t.
    task automatic push_model(input logic [W-1:0] xv, input logic [W-1:0] ellv);
        int t = 0;
        int p, n, xm, rev, r;
        exp_t e;
        for (int i = 0; i < W; i++) t += int'(ellv[i]);
        p  = W - t;
        n  = 1 << p;
        xm = int'(xv & ~ellv);
        for (int c = 0; c < n; c++) begin
            rev = 0;
            for (int j = 0; j < p; j++)
                if (((c >> j) & 1) == 1) rev |= 1 << (p - 1 - j);
            r      = (rev << t) & 'hFF;
            e.z    = (xm > r);
            e.last = (c == n - 1);
            sb.push_back(e);
        end
        exp_ones = xm >> t;
    endtask

    // Drive a start at the current negedge; returns one cycle later.
    task automatic drive_start(input logic [W-1:0] xv, input logic [W-1:0] ellv);
        start_i = 1'b1;
        x_i     = xv;
        ell_i   = ellv;
        push_model(xv, ellv);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_busy"},    busy_o,    0);
        chk({tag, "_z_valid"}, z_valid_o, 0);
        chk({tag, "_z"},       z_o,       0);
        chk({tag, "_z_last"},  z_last_o,  0);
        chk({tag, "_done"},    done_o,    32'(exp_done));
    endtask

    // Consume queued bits, one per cycle, with no bubbles allowed.
    // poke_idx : pulse start (with other operands) at that bit
    // abort_idx: pulse abort at that bit
    // rst_idx  : pulse rst_n low at that bit
    task automatic run_bits(input string tag, input int poke_idx,
                            input int abort_idx, input int rst_idx);
        int   n   = 0;
        bit   fin = 0;
        exp_t e;
        got_ones = 0;
        while (!fin && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_z_valid"}, z_valid_o, 1);
            chk({tag, "_busy"},    busy_o,    1);
            chk({tag, "_z"},       z_o,       32'(e.z));
            chk({tag, "_z_last"},  z_last_o,  32'(e.last));
            chk({tag, "_done_run"}, done_o,   0);
            got_ones += int'(z_o);
            fin = e.last;
            start_i = 1'b0;
            abort_i = 1'b0;
            if (n == poke_idx) begin
                start_i = 1'b1;
                x_i     = 8'hFF;
                ell_i   = 8'h00;
            end
            if (n == rst_idx) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                chk_idle({tag, "_after_rst"}, 1'b0);
                sb.delete();
                return;
            end
            if (n == abort_idx) begin
                abort_i = 1'b1;
`ifdef VPSNG_ABORT_EN
                @(negedge clk);
                abort_i = 1'b0;
                chk_idle({tag, "_after_abort"}, 1'b0);
                sb.delete();
                return;
`endif
            end
            n++;
            @(negedge clk);
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        // Done cycle
        chk_idle({tag, "_done_cycle"}, 1'b1);
        chk({tag, "_ones"}, got_ones, exp_ones);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full-precision stream: 256 bits, 180 ones
        drive_start(8'hB4, 8'h00);
        run_bits("full", -1, -1, -1);
        @(negedge clk);
        chk("full_done_once", done_o, 0);

        // 16-bit stream, 11 ones
        drive_start(8'hB7, 8'h0F);
        run_bits("ell0f", -1, -1, -1);
        @(negedge clk);

        // Degenerate single-bit stream
        drive_start(8'h5A, 8'hFF);
        run_bits("ellff", -1, -1, -1);
        @(negedge clk);

        // Back-to-back with an ignored start during RUN
        drive_start(8'h95, 8'h0F);
        run_bits("b2b_a", 5, -1, -1);
        drive_start(8'h6E, 8'h07);       // issued in the done cycle
        run_bits("b2b_b", -1, -1, -1);
        @(negedge clk);
        chk("b2b_done_once", done_o, 0);

        // Reset in the middle of a 256-bit stream
        drive_start(8'hB4, 8'h00);
        run_bits("midrst", -1, -1, 37);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("midrst_quiet", 1'b0);
        end
        drive_start(8'h4D, 8'h00);
        run_bits("post_rst", -1, -1, -1);
        @(negedge clk);

        // Abort at bit 10 of a 64-bit stream
        drive_start(8'hA9, 8'h03);
        run_bits("abort", -1, 10, -1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_idle("abort_quiet", 1'b0);
        end

        // Short stream after the abort test to show the block is usable
        drive_start(8'hC3, 8'h3F);
        run_bits("tail", -1, -1, -1);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
